// File: rtl/if_stage_ctrl.sv
// Instruction-fetch front end: drives the PC, the instruction-memory request and the IF/ID pipeline register.
// Handles hazard stalls, redirects, fetch wait states and ECALL halt.
module if_stage_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_write,
  input  logic        IF_ID_write,
  input  logic        flush,
  input  logic [31:0] branch_target,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] IF_ID_inst,
  output logic [31:0] IF_ID_pc,
  output logic        IF_ID_valid,
  output logic        fetch_busy,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_HOLD,
    S_HALTED
  } state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{inst: NOP_INST, pc: 32'h0, valid: 1'b0};

  state_t      r_state;
  logic [31:0] r_pc;
  if_id_t      r_if_id;
  if_id_t      r_hold;
  logic [31:0] r_stall_count;

  logic w_busy;
  logic w_stall_evt;
  logic w_release;

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign w_busy      = imem_req && !imem_ready;
  assign fetch_busy  = w_busy;
  assign w_release   = IF_ID_write && pc_write;

  // Halt and flush edges are redirects, not stalls, so they never count.
  assign w_stall_evt = (r_state != S_HALTED) && !halt && !flush && (!pc_write || w_busy);

  assign IF_ID_inst  = r_if_id.inst;
  assign IF_ID_pc    = r_if_id.pc;
  assign IF_ID_valid = r_if_id.valid;
  assign stall_count = r_stall_count;

  // NOTE: every register here is updated with <= so all of them see the pre-edge
  // values of each other; a blocking = would make later statements observe new state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_FETCH;
      r_pc          <= RESET_PC;
      r_if_id       <= BUBBLE;
      r_hold        <= BUBBLE;
      r_stall_count <= 32'h0;
    end else begin
      if (w_stall_evt && (r_stall_count != 32'hFFFF_FFFF))
        r_stall_count <= r_stall_count + 32'd1;

      if (r_state != S_HALTED) begin
        if (halt) begin
          r_state <= S_HALTED;
          r_if_id <= BUBBLE;
        end else if (flush) begin
          r_state <= S_FETCH;
          r_pc    <= branch_target;
          r_if_id <= BUBBLE;
          r_hold  <= BUBBLE;
        end else begin
          case (r_state)
            S_FETCH: begin
              if (imem_ready) begin
                if (w_release) begin
                  r_if_id <= '{inst: imem_data, pc: r_pc, valid: 1'b1};
                  r_pc    <= r_pc + 32'd4;
                end else begin
                  // Either stall input blocks delivery: park the word so it is not refetched.
                  r_hold  <= '{inst: imem_data, pc: r_pc, valid: 1'b1};
                  r_state <= S_HOLD;
                end
              end else if (IF_ID_write) begin
                r_if_id <= BUBBLE;
              end
            end
            S_HOLD: begin
              if (w_release) begin
                r_if_id <= r_hold;
                r_pc    <= r_pc + 32'd4;
                r_state <= S_FETCH;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Directed table-driven bench for if_stage_ctrl: per cycle it checks the pre-edge fetch
// outputs, then the IF/ID register and stall counter after the edge.
module tb_if_stage_ctrl;

  logic        clk;
  logic        reset;
  logic        pc_write;
  logic        IF_ID_write;
  logic        flush;
  logic [31:0] branch_target;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] IF_ID_inst;
  logic [31:0] IF_ID_pc;
  logic        IF_ID_valid;
  logic        fetch_busy;
  logic [31:0] stall_count;

  int checks;
  int failures;

  localparam logic [31:0] NOP = 32'h0000_0013;

  if_stage_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .pc_write     (pc_write),
    .IF_ID_write  (IF_ID_write),
    .flush        (flush),
    .branch_target(branch_target),
    .halt         (halt),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_data    (imem_data),
    .IF_ID_inst   (IF_ID_inst),
    .IF_ID_pc     (IF_ID_pc),
    .IF_ID_valid  (IF_ID_valid),
    .fetch_busy   (fetch_busy),
    .stall_count  (stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle of stimulus: inputs, expected pre-edge fetch outputs, expected post-edge state.
  typedef struct packed {
    logic        pw, iw, fl, hl, rdy;
    logic [31:0] tgt, data;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_busy;
    logic [31:0] e_inst, e_pc;
    logic        e_valid;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic pw, iw, fl, hl, rdy, input logic [31:0] tgt, data,
                              input logic req, input logic [31:0] addr, input logic busy,
                              input logic [31:0] inst, pc, input logic valid,
                              input logic [31:0] cnt);
    vec_t v;
    v.pw = pw; v.iw = iw; v.fl = fl; v.hl = hl; v.rdy = rdy;
    v.tgt = tgt; v.data = data;
    v.e_req = req; v.e_addr = addr; v.e_busy = busy;
    v.e_inst = inst; v.e_pc = pc; v.e_valid = valid; v.e_cnt = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    reset         = 1'b0;
    pc_write      = v.pw;
    IF_ID_write   = v.iw;
    flush         = v.fl;
    halt          = v.hl;
    imem_ready    = v.rdy;
    branch_target = v.tgt;
    imem_data     = v.data;
    #1;
    check({tag, ".req"},  {31'h0, imem_req},   {31'h0, v.e_req});
    check({tag, ".addr"}, imem_addr,           v.e_addr);
    check({tag, ".busy"}, {31'h0, fetch_busy}, {31'h0, v.e_busy});
    @(posedge clk);
    #1;
    check({tag, ".inst"},  IF_ID_inst,           v.e_inst);
    check({tag, ".pc"},    IF_ID_pc,             v.e_pc);
    check({tag, ".valid"}, {31'h0, IF_ID_valid}, {31'h0, v.e_valid});
    check({tag, ".cnt"},   stall_count,          v.e_cnt);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".addr"},  imem_addr,            32'h0);
    check({tag, ".req"},   {31'h0, imem_req},    32'h1);
    check({tag, ".inst"},  IF_ID_inst,           NOP);
    check({tag, ".pc"},    IF_ID_pc,             32'h0);
    check({tag, ".valid"}, {31'h0, IF_ID_valid}, 32'h0);
    check({tag, ".cnt"},   stall_count,          32'h0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    pc_write = 1'b1;
    IF_ID_write = 1'b1;
    flush = 1'b0;
    halt = 1'b0;
    imem_ready = 1'b0;
    branch_target = 32'h0;
    imem_data = 32'h0;

    //                pw  iw  fl  hl  rdy  tgt           data           req  addr          busy  inst           pc            v   cnt
    vecs[0]  = mk(1, 1, 0, 0, 1, 32'h0,        32'h00A00093, 1, 32'h0,        0, 32'h00A00093, 32'h0,        1, 32'd0);
    vecs[1]  = mk(1, 1, 0, 0, 1, 32'h0,        32'h00100113, 1, 32'h4,        0, 32'h00100113, 32'h4,        1, 32'd0);
    vecs[2]  = mk(0, 0, 0, 0, 1, 32'h0,        32'h11111111, 1, 32'h8,        0, 32'h00100113, 32'h4,        1, 32'd1);
    vecs[3]  = mk(1, 1, 0, 0, 0, 32'h0,        32'hDEADBEEF, 0, 32'h8,        0, 32'h11111111, 32'h8,        1, 32'd1);
    vecs[4]  = mk(1, 1, 0, 0, 1, 32'h0,        32'h22222222, 1, 32'hC,        0, 32'h22222222, 32'hC,        1, 32'd1);
    vecs[5]  = mk(1, 1, 0, 0, 0, 32'h0,        32'h0,        1, 32'h10,       1, NOP,          32'h0,        0, 32'd2);
    vecs[6]  = mk(1, 1, 0, 0, 0, 32'h0,        32'h0,        1, 32'h10,       1, NOP,          32'h0,        0, 32'd3);
    vecs[7]  = mk(1, 1, 0, 0, 0, 32'h0,        32'h0,        1, 32'h10,       1, NOP,          32'h0,        0, 32'd4);
    vecs[8]  = mk(1, 1, 0, 0, 1, 32'h0,        32'h33333333, 1, 32'h10,       0, 32'h33333333, 32'h10,       1, 32'd4);
    vecs[9]  = mk(0, 1, 0, 0, 1, 32'h0,        32'h44444444, 1, 32'h14,       0, 32'h33333333, 32'h10,       1, 32'd5);
    vecs[10] = mk(0, 1, 0, 0, 1, 32'h0,        32'h0,        0, 32'h14,       0, 32'h33333333, 32'h10,       1, 32'd6);
    vecs[11] = mk(1, 0, 0, 0, 1, 32'h0,        32'h0,        0, 32'h14,       0, 32'h33333333, 32'h10,       1, 32'd6);
    vecs[12] = mk(1, 1, 0, 0, 0, 32'h0,        32'h0,        0, 32'h14,       0, 32'h44444444, 32'h14,       1, 32'd6);
    vecs[13] = mk(1, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h18,       1, 32'h44444444, 32'h14,       1, 32'd7);
    vecs[14] = mk(0, 0, 1, 0, 1, 32'h200,      32'h55555555, 1, 32'h18,       0, NOP,          32'h0,        0, 32'd7);
    vecs[15] = mk(1, 1, 0, 0, 1, 32'h0,        32'h66666666, 1, 32'h200,      0, 32'h66666666, 32'h200,      1, 32'd7);
    vecs[16] = mk(0, 0, 0, 0, 1, 32'h0,        32'h77777777, 1, 32'h204,      0, 32'h66666666, 32'h200,      1, 32'd8);
    vecs[17] = mk(0, 1, 1, 0, 1, 32'h300,      32'h0,        0, 32'h204,      0, NOP,          32'h0,        0, 32'd8);
    vecs[18] = mk(1, 1, 0, 0, 1, 32'h0,        32'h88888888, 1, 32'h300,      0, 32'h88888888, 32'h300,      1, 32'd8);
    vecs[19] = mk(0, 1, 1, 1, 1, 32'h400,      32'h99999999, 1, 32'h304,      0, NOP,          32'h0,        0, 32'd8);
    vecs[20] = mk(0, 0, 1, 0, 0, 32'h500,      32'h0,        0, 32'h304,      0, NOP,          32'h0,        0, 32'd8);
    vecs[21] = mk(1, 1, 0, 0, 1, 32'h0,        32'hAAAAAAAA, 0, 32'h304,      0, NOP,          32'h0,        0, 32'd8);

    #2;
    check_reset_state("reset");

    for (int i = 0; i < 22; i++)
      run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset out of HALTED resumes fetching at RESET_PC.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("rst_halted");
    run_vec(mk(1, 1, 0, 0, 1, 32'h0, 32'h99999999, 1, 32'h0, 0, 32'h99999999, 32'h0, 1, 32'd0), "resume");

    // Reset while a word sits in the hold buffer discards it.
    run_vec(mk(0, 0, 0, 0, 1, 32'h0, 32'hBBBBBBBB, 1, 32'h4, 0, 32'h99999999, 32'h0, 1, 32'd1), "hold_in");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_state("rst_hold");
    run_vec(mk(1, 1, 0, 0, 1, 32'h0, 32'hCCCCCCCC, 1, 32'h0, 0, 32'hCCCCCCCC, 32'h0, 1, 32'd0), "post_hold");

    // PC wrap at the top of the address space.
    run_vec(mk(1, 1, 1, 0, 0, 32'hFFFF_FFFC, 32'h0, 1, 32'h4, 1, NOP, 32'h0, 0, 32'd0), "to_top");
    run_vec(mk(1, 1, 0, 0, 1, 32'h0, 32'hABCDEF01, 1, 32'hFFFF_FFFC, 0, 32'hABCDEF01, 32'hFFFF_FFFC, 1, 32'd0), "top");
    run_vec(mk(1, 0, 0, 0, 0, 32'h0, 32'h0, 1, 32'h0, 1, 32'hABCDEF01, 32'hFFFF_FFFC, 1, 32'd1), "wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
